// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Command-register field width; keep equal to the arbiter's DATA_WIDTH.
  localparam int unsigned CMD_DATA_WIDTH = 32;

  localparam logic [1:0] MODE_BYTE    = 2'b00;
  localparam logic [1:0] MODE_HALF    = 2'b01;
  localparam logic [1:0] MODE_WORD    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                      port;
    logic                      we;
    logic [CMD_DATA_WIDTH-1:0] addr;
    logic [1:0]                mode;
    logic                      sext;
    logic [CMD_DATA_WIDTH-1:0] wdata;
    logic                      err;
  } cmd_t;

  function automatic logic access_error(input logic [1:0] mode,
                                        input logic [1:0] addr_lsb);
    logic bad;
    bad = 1'b1;
    case (mode)
      MODE_BYTE: bad = 1'b0;
      MODE_HALF: bad = addr_lsb[0];
      MODE_WORD: bad = |addr_lsb;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
// Module      : mem_arb_rr
// Description : Two-port round-robin grant logic with last-grant pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_last;

  // On a tie the port that was not granted last wins.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|gnt) begin
      r_last <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port data-memory arbiter, one access per two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0][1:0]            mode_i,
  input  logic [NUM_PORTS-1:0]                 sext_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]                 gnt_o,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]                 err_o,
  output logic [DATA_WIDTH-1:0]                mem_A,
  output logic                                 mem_WE,
  output logic [1:0]                           mem_addressing_mode,
  output logic                                 mem_sign_extend,
  output logic [DATA_WIDTH-1:0]                mem_WD,
  input  logic [DATA_WIDTH-1:0]                mem_RD
);

  arb_state_e                           r_state;
  arb_state_e                           w_state_next;
  cmd_t                                 r_cmd;
  cmd_t                                 w_cmd_next;
  logic                                 r_run;
  logic [NUM_PORTS-1:0]                 w_gnt;
  logic                                 w_sel;
  logic                                 w_mem_en;
  logic [NUM_PORTS-1:0]                 r_rvalid;
  logic [NUM_PORTS-1:0]                 r_err;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rdata;

  mem_arb_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((r_state == IDLE) && r_run),
    .req   (req_i),
    .gnt   (w_gnt)
  );

  assign w_sel = w_gnt[1];
  assign gnt_o = w_gnt;

  // Holds off grants until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_next   = r_cmd;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_state_next     = ACCESS;
          w_cmd_next.port  = w_sel;
          w_cmd_next.we    = we_i[w_sel];
          w_cmd_next.addr  = CMD_DATA_WIDTH'(addr_i[w_sel]);
          w_cmd_next.mode  = mode_i[w_sel];
          w_cmd_next.sext  = sext_i[w_sel];
          w_cmd_next.wdata = CMD_DATA_WIDTH'(wdata_i[w_sel]);
          w_cmd_next.err   = access_error(mode_i[w_sel], addr_i[w_sel][1:0]);
        end
      end
      ACCESS:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cmd   <= w_cmd_next;
    end
  end

  // Memory port is quiet except during a legal ACCESS cycle.
  assign w_mem_en            = (r_state == ACCESS) && !r_cmd.err;
  assign mem_WE              = w_mem_en && r_cmd.we;
  assign mem_A               = w_mem_en ? DATA_WIDTH'(r_cmd.addr)  : '0;
  assign mem_WD              = w_mem_en ? DATA_WIDTH'(r_cmd.wdata) : '0;
  assign mem_addressing_mode = w_mem_en ? r_cmd.mode : 2'b00;
  assign mem_sign_extend     = w_mem_en && r_cmd.sext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_state == ACCESS) begin
        r_rvalid[r_cmd.port] <= 1'b1;
        r_err[r_cmd.port]    <= r_cmd.err;
        r_rdata[r_cmd.port]  <= (r_cmd.we || r_cmd.err) ? '0 : mem_RD;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_i  = '0;
  logic [1:0]          we_i   = '0;
  logic [1:0]          sext_i = '0;
  logic [1:0][DW-1:0]  addr_i  = '0;
  logic [1:0][DW-1:0]  wdata_i = '0;
  logic [1:0][1:0]     mode_i  = '0;
  logic [1:0]          gnt_o, rvalid_o, err_o;
  logic [1:0][DW-1:0]  rdata_o;
  logic [DW-1:0]       mem_A, mem_WD, mem_RD;
  logic                mem_WE, mem_sign_extend;
  logic [1:0]          mem_addressing_mode;
  logic [9:0]          ma;

  logic [7:0] mem [0:1023];
  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int dbl_rv   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_i               (req_i),
    .we_i                (we_i),
    .addr_i              (addr_i),
    .mode_i              (mode_i),
    .sext_i              (sext_i),
    .wdata_i             (wdata_i),
    .gnt_o               (gnt_o),
    .rvalid_o            (rvalid_o),
    .rdata_o             (rdata_o),
    .err_o               (err_o),
    .mem_A               (mem_A),
    .mem_WE              (mem_WE),
    .mem_addressing_mode (mem_addressing_mode),
    .mem_sign_extend     (mem_sign_extend),
    .mem_WD              (mem_WD),
    .mem_RD              (mem_RD)
  );

  // Byte-addressed little-endian data memory with size/sign handling.
  assign ma = mem_A[9:0];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
  end

  always @(posedge clk) begin
    if (mem_WE) begin
      case (mem_addressing_mode)
        2'b00: mem[ma] <= mem_WD[7:0];
        2'b01: begin
          mem[ma]   <= mem_WD[7:0];
          mem[ma+1] <= mem_WD[15:8];
        end
        2'b10: begin
          mem[ma]   <= mem_WD[7:0];
          mem[ma+1] <= mem_WD[15:8];
          mem[ma+2] <= mem_WD[23:16];
          mem[ma+3] <= mem_WD[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_RD = '0;
    case (mem_addressing_mode)
      2'b00: mem_RD = {{24{mem_sign_extend & mem[ma][7]}}, mem[ma]};
      2'b01: mem_RD = {{16{mem_sign_extend & mem[ma+1][7]}}, mem[ma+1], mem[ma]};
      2'b10: mem_RD = {mem[ma+3], mem[ma+2], mem[ma+1], mem[ma]};
      default: mem_RD = '0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_WE) we_cnt <= we_cnt + 1;
      if (rvalid_o == 2'b11) dbl_rv <= dbl_rv + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One complete transaction on port p; lat counts negedges from grant to rvalid.
  task automatic access(input int p, input logic we, input logic [31:0] addr,
                        input logic [1:0] mode, input logic sext, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    int t;
    rd  = '0;
    e   = 1'b0;
    lat = -1;
    @(negedge clk);
    req_i[p] = 1'b1; we_i[p] = we; addr_i[p] = addr;
    mode_i[p] = mode; sext_i[p] = sext; wdata_i[p] = wd;
    t = 0;
    #1;
    while (!gnt_o[p] && t < 10) begin
      @(negedge clk); #1; t++;
    end
    if (!gnt_o[p]) begin
      check("gnt_timeout", 32'd0, 32'd1);
      req_i[p] = 1'b0;
      return;
    end
    @(negedge clk);
    req_i[p] = 1'b0;
    t = 1;
    #1;
    while (!rvalid_o[p] && t < 10) begin
      @(negedge clk); #1; t++;
    end
    if (!rvalid_o[p]) begin
      check("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    rd  = rdata_o[p];
    e   = err_o[p];
    lat = t;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, we0, dbl_gnt, rv_seen;
    int          gport[$];
    int          gcyc[$];

    // Reset state, with both ports requesting to prove grants are held off.
    rst_n = 1'b0;
    req_i = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_rvalid", rvalid_o, 2'b00);
    check("rst_err", err_o, 2'b00);
    check("rst_rdata0", rdata_o[0], 32'h0);
    check("rst_rdata1", rdata_o[1], 32'h0);
    check("rst_mem_we", mem_WE, 1'b0);
    check("rst_mem_a", mem_A, 32'h0);
    req_i = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports requesting continuously: alternate from port 0.
    @(negedge clk);
    we_i = 2'b00; mode_i = {MODE_WORD, MODE_WORD};
    addr_i[0] = 32'h0; addr_i[1] = 32'h4;
    req_i = 2'b11;
    dbl_gnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (gnt_o == 2'b11) dbl_gnt++;
      if (|gnt_o) begin
        gport.push_back(int'(gnt_o[1]));
        gcyc.push_back(k);
      end
      @(negedge clk);
    end
    req_i = 2'b00;
    check("rr_grant_count", gport.size(), 6);
    if (gport.size() >= 4) begin
      check("rr_g0", gport[0], 0);
      check("rr_g1", gport[1], 1);
      check("rr_g2", gport[2], 0);
      check("rr_g3", gport[3], 1);
      check("rr_first_cycle", gcyc[0], 0);
      check("rr_spacing01", gcyc[1] - gcyc[0], 2);
      check("rr_spacing23", gcyc[3] - gcyc[2], 2);
    end
    check("rr_double_gnt", dbl_gnt, 0);
    repeat (3) @(negedge clk);
    check("rr_double_rvalid", dbl_rv, 0);

    // Store word then load it back on port 0.
    we0 = we_cnt;
    access(0, 1'b1, 32'h100, MODE_WORD, 1'b0, 32'hDEADBEEF, rd, e, lat);
    check("sw_latency", lat, 2);
    check("sw_we_cycles", we_cnt - we0, 1);
    check("sw_err", e, 1'b0);
    check("sw_rdata", rd, 32'h0);
    access(0, 1'b0, 32'h100, MODE_WORD, 1'b0, 32'h0, rd, e, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", e, 1'b0);
    check("lw_latency", lat, 2);

    // Byte/half sign handling around 0x203.
    access(0, 1'b1, 32'h203, MODE_BYTE, 1'b0, 32'h00000080, rd, e, lat);
    check("sb_err", e, 1'b0);
    access(0, 1'b0, 32'h203, MODE_BYTE, 1'b1, 32'h0, rd, e, lat);
    check("lb_rdata", rd, 32'hFFFFFF80);
    access(0, 1'b0, 32'h203, MODE_BYTE, 1'b0, 32'h0, rd, e, lat);
    check("lbu_rdata", rd, 32'h00000080);
    access(1, 1'b0, 32'h202, MODE_HALF, 1'b1, 32'h0, rd, e, lat);
    check("lh_rdata", rd, 32'hFFFF8000);
    check("lh_err", e, 1'b0);

    // Misaligned and illegal accesses: error, no write, memory intact.
    we0 = we_cnt;
    access(1, 1'b1, 32'h101, MODE_HALF, 1'b0, 32'h00001234, rd, e, lat);
    check("sh_mis_err", e, 1'b1);
    check("sh_mis_rdata", rd, 32'h0);
    access(1, 1'b1, 32'h102, MODE_WORD, 1'b0, 32'h55667788, rd, e, lat);
    check("sw_mis_err", e, 1'b1);
    check("sw_mis_rdata", rd, 32'h0);
    access(1, 1'b1, 32'h100, MODE_ILLEGAL, 1'b0, 32'h11111111, rd, e, lat);
    check("mode11_err", e, 1'b1);
    check("mode11_latency", lat, 2);
    check("err_no_we", we_cnt - we0, 0);
    check("err_mem_intact", {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]}, 32'hDEADBEEF);
    access(0, 1'b0, 32'h100, MODE_WORD, 1'b0, 32'h0, rd, e, lat);
    check("lw_after_err", rd, 32'hDEADBEEF);
    access(0, 1'b0, 32'h101, MODE_WORD, 1'b0, 32'h0, rd, e, lat);
    check("lw_mis_rdata", rd, 32'h0);
    check("lw_mis_err", e, 1'b1);

    // Reset asserted during ACCESS of a port-0 store to 0x40.
    @(negedge clk);
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'h40;
    mode_i[0] = MODE_WORD; wdata_i[0] = 32'h12345678;
    #1;
    check("abort_gnt", gnt_o, 2'b01);
    @(negedge clk);
    req_i[0] = 1'b0;
    #1;
    check("abort_we_before", mem_WE, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_we_after", mem_WE, 1'b0);
    rv_seen = 0;
    @(negedge clk);
    #1;
    if (|rvalid_o) rv_seen++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (|rvalid_o) rv_seen++;
    end
    check("abort_no_rvalid", rv_seen, 0);
    check("abort_mem_intact", {mem[32'h43], mem[32'h42], mem[32'h41], mem[32'h40]}, 32'h0);
    @(negedge clk);
    we_i = 2'b00; mode_i = {MODE_WORD, MODE_WORD};
    addr_i[0] = 32'h0; addr_i[1] = 32'h4;
    req_i = 2'b11;
    #1;
    check("post_rst_tie", gnt_o, 2'b01);
    @(negedge clk);
    req_i = 2'b00;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of address, write-data and read-data buses.
REQ-002 Parameter NUM_PORTS, fixed at 2; port 0 is the CPU load/store unit and port 1 is the debug/loader port.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_i[p]  input  1  port p requests an access; held with its fields until gnt_o[p].
REQ-006 we_i[p]  input  1  1 = store, 0 = load.
REQ-007 addr_i[p]  input  DATA_WIDTH  byte address.
REQ-008 mode_i[p]  input  2  addressing mode: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 sext_i[p]  input  1  sign-extend the load result (byte/half only).
REQ-010 wdata_i[p]  input  DATA_WIDTH  store data, LSB-aligned.
REQ-011 gnt_o[p]  output  1  one-cycle pulse: the request was accepted this cycle.
REQ-012 rvalid_o[p]  output  1  one-cycle pulse: response available.
REQ-013 rdata_o[p]  output  DATA_WIDTH  load data; 0 for stores and errors; held until the next rvalid_o[p].
REQ-014 err_o[p]  output  1  qualified by rvalid_o[p]: the access was misaligned or illegal.
REQ-015 mem_A, mem_WE, mem_addressing_mode, mem_sign_extend, mem_WD  outputs  DATA_WIDTH/1/2/1/DATA_WIDTH  drive the data-memory port.
REQ-016 mem_RD  input  DATA_WIDTH  combinational read data from the memory.

Function
REQ-017 FSM states: IDLE and ACCESS.
REQ-018 IDLE with no requests: remain in IDLE.
REQ-019 IDLE with at least one request: assert gnt_o for exactly one port combinationally; capture that port's fields into the command register at the posedge; go to ACCESS.
REQ-020 Arbitration is round-robin:
- A sole requester wins.
- If both ports request, the port not granted last wins.
- The last-grant pointer updates on every grant.
REQ-021 ACCESS always lasts exactly one cycle, then the FSM returns to IDLE.
REQ-022 During ACCESS the memory outputs are driven from the command register; mem_WE = cmd_we and no error.
REQ-023 Outside ACCESS (or during an erroring ACCESS):
- mem_WE = 0.
- mem_A, mem_WD, mem_addressing_mode and mem_sign_extend = 0.
REQ-024 At the posedge ending ACCESS, rdata_o[cmd_port] is loaded:
- mem_RD for a load.
- 0 for a store or an error.
REQ-025 rvalid_o[cmd_port] pulses in the cycle after ACCESS; err_o[cmd_port] is set accordingly.
REQ-026 Latency: grant in cycle T, memory access in T+1, rvalid in T+2; sustained throughput is 1 access per 2 cycles.
REQ-027 A new grant may occur in the same cycle as rvalid of the previous access.
REQ-028 An error is any of:
- mode 11;
- mode 01 with addr[0]=1;
- mode 10 with addr[1:0] != 00.
REQ-029 An erroring access still consumes the ACCESS cycle, never asserts mem_WE, and completes with rvalid and err_o = 1.
REQ-030 gnt_o is never asserted in ACCESS; a request arriving during ACCESS waits in IDLE.
REQ-031 At most one gnt_o bit and at most one rvalid_o bit are high in any cycle.
REQ-032 Deasserting req before grant withdraws the request; no state change results.

Reset
REQ-033 On rst_n low, immediately:
- state = IDLE, last-grant pointer = port 1 (so port 0 wins the first tie);
- command register = 0;
- all gnt_o, rvalid_o, err_o, rdata_o = 0;
- mem_WE = 0.
REQ-034 Reset during ACCESS aborts the access: no memory write after reset assertion and no rvalid for it.
REQ-035 After rst_n deasserts, the first grant occurs no earlier than the first posedge.

Structure
REQ-036 Shared package mem_arb_pkg holds:
- the state enum (IDLE, ACCESS);
- mode constants MODE_BYTE = 00, MODE_HALF = 01, MODE_WORD = 10;
- the command-register struct (port, we, addr, mode, sext, wdata, err).
REQ-037 One sub-module, mem_arb_rr: the 2-port round-robin grant logic with its pointer register.
REQ-038 FSM, command register, alignment check and response registers live in mem_arbiter.

Verification
REQ-039 Port 0 only, store word 0xDEADBEEF to 0x100, then load word 0x100:
- gnt at T, mem_WE high at T+1 only;
- second rvalid_o[0] with rdata 0xDEADBEEF, err 0.
REQ-040 Both ports request continuously:
- grants alternate 0,1,0,1 starting with port 0;
- one grant every 2 cycles, never two rvalids at once.
REQ-041 Byte 0x80 stored at 0x203:
- lb returns 0xFFFFFF80; lbu returns 0x00000080;
- lh from 0x202 with sext=1 returns sign-extended {mem[0x203], mem[0x202]}.
REQ-042 Store half to 0x101 and store word to 0x102 and mode 11:
- each gives rvalid with err 1, rdata 0;
- mem_WE stays 0 throughout and memory is unchanged.
REQ-043 rst_n pulled low during ACCESS of a store to 0x40:
- mem_WE drops immediately and no rvalid is issued;
- the next tie goes to port 0.
